rrc_pam4_upsampler: RTL and testbench
=====================================

Name: rrc_pam4_upsampler

Overview:
Transmit-side stage directly upstream of the 33-tap RRC pulse-shaping filter.
- Accepts 2-bit PAM-4 symbols over a valid/ready handshake.
- Buffers them in a small FIFO and Gray-maps each one to a signed Q1.8 amplitude.
- Zero-stuffs by OSR so the filter receives exactly one sample per clock (one symbol sample followed by OSR-1 zeros).
- Tracks underruns, where a symbol slot arrives with the FIFO empty.

Parameters:
- WIDTH, 9: output sample width in bits, signed Q1.8, matches the filter input.
- OSR, 4: oversampling ratio, i.e. samples per symbol. Legal range 2..16.
- FIFO_DEPTH, 4: symbol FIFO entries. Power of two, range 2..16.
- LEVEL_A, 64: inner constellation amplitude a. 3*LEVEL_A must be ≤ 255.

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- en, input, 1: streaming enable.
- flush, input, 1: synchronous FIFO clear.
- sym_data, input, 2: PAM-4 symbol bits.
- sym_valid, input, 1: upstream symbol valid.
- sym_ready, output, 1: FIFO can accept a symbol.
- sample_out, output, WIDTH: signed sample to the filter input.
- sym_strobe, output, 1: sample_out holds a symbol-slot sample.
- underflow_cnt, output, 8: saturating underrun count.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - sample_out = 0, sym_strobe = 0, underflow_cnt = 0.
  - Phase counter = 0, FIFO empty.
  - sym_ready = 1 while in reset and after release.
- Handshake:
  - sym_ready = (fifo_count < FIFO_DEPTH), combinational from registered count only.
  - A push occurs when sym_valid && sym_ready on a clock edge.
  - sym_data must be held stable while sym_valid = 1 and sym_ready = 0.
- Gray mapping:
  - 00 → -3*LEVEL_A
  - 01 → -LEVEL_A
  - 11 → +LEVEL_A
  - 10 → +3*LEVEL_A
  - Defaults give -192, -64, +64, +192.
  - Result is sign-correct at WIDTH bits; no saturation is needed because of the parameter constraint.
- Phase counter:
  - Counts 0..OSR-1 and wraps to 0. Advances every cycle while en = 1.
  - While en = 0 it is forced to 0 and sample_out is registered as 0.
- Phase 0 (slot cycle) with en = 1:
  - If the FIFO is non-empty: pop the head and register mapped(head) into sample_out; sym_strobe = 1 the following cycle.
  - If the FIFO is empty: register sample_out = 0, sym_strobe = 1, and increment underflow_cnt, saturating at 255.
- Phases 1..OSR-1: sample_out = 0, sym_strobe = 0.
- Latency: a symbol pushed at edge t, with the FIFO previously empty and the phase-0 cycle falling between edges t and t+1, appears on sample_out after edge t+1.
  - The FIFO has no bypass: a pop only sees entries written on earlier edges.
- Simultaneous push and pop:
  - Both occur; count is unchanged.
  - When the FIFO is full, no push is possible because sym_ready = 0.
- flush = 1:
  - Empties the FIFO at the next edge and blocks that cycle's push and pop.
  - Phase counter and underflow_cnt are unaffected.
  - If the cycle is phase 0 with en = 1, it is treated as an underrun.
- en falling mid-symbol: the remaining zero samples are dropped; the next en = 1 restarts at phase 0. FIFO contents are kept.
- Pointers: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low for 3 cycles, then en = 0 for 10 cycles.
  - Required: sample_out = 0, sym_strobe = 0, underflow_cnt = 0, sym_ready = 1 throughout.
- Mapping sweep:
  - Stimulus: en = 1; push 00, 01, 11, 10 back-to-back.
  - Required: sample_out sequence -192, 0, 0, 0, -64, 0, 0, 0, +64, 0, 0, 0, +192, 0, 0, 0.
  - sym_strobe is high exactly on the nonzero-slot cycles, one every 4 cycles.
- Backpressure:
  - Stimulus: en = 0; hold sym_valid = 1 for 6 cycles.
  - Required: exactly 4 pushes accepted, sym_ready = 0 after the 4th.
  - Stimulus: then en = 1.
  - Required: sym_ready returns to 1 the cycle after the first pop; no symbol is lost or duplicated.
- Underrun:
  - Stimulus: en = 1 with no symbols for 40 cycles.
  - Required: sample_out = 0 and underflow_cnt = 10.
  - Stimulus: continue for 1100 cycles.
  - Required: underflow_cnt saturates at 255.
- Flush and enable drop:
  - Stimulus: fill 3 symbols; assert flush for 1 cycle.
  - Required: next 3 slots are underruns (cnt +3), sym_ready = 1.
  - Stimulus: deassert en at phase 2.
  - Required: phase restarts at 0 when en returns.
- Reset mid-operation:
  - Stimulus: assert rst_n low asynchronously between edges while sample_out = +192 and the FIFO holds 2 symbols.
  - Required: outputs go to 0 immediately; after release the FIFO is empty and the first slot is an underrun.

Source files
------------

// File: rtl/rrc_pam4_upsampler.sv
`default_nettype none
// ============================================================================
// Module   : rrc_pam4_upsampler
// Brief    : PAM-4 symbol FIFO, Gray mapper and zero-stuffing upsampler that
//            feeds one Q1.8 sample per clock into the RRC pulse-shaping filter.
//            Counts (saturating) symbol slots that find the FIFO empty.
// Revision : 1.0 - initial release
// ============================================================================
module rrc_pam4_upsampler #(
  parameter int WIDTH      = 9,
  parameter int OSR        = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LEVEL_A    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    flush,
  input  logic [1:0]              sym_data,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic signed [WIDTH-1:0] sample_out,
  output logic                    sym_strobe,
  output logic [7:0]              underflow_cnt
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PW + 1;
  localparam int PHW   = $clog2(OSR);

  // Gray-coded constellation levels, sign-extended to the filter width
  localparam logic signed [WIDTH-1:0] c_neg3 = WIDTH'(-3 * LEVEL_A);
  localparam logic signed [WIDTH-1:0] c_neg1 = WIDTH'(-LEVEL_A);
  localparam logic signed [WIDTH-1:0] c_pos1 = WIDTH'(LEVEL_A);
  localparam logic signed [WIDTH-1:0] c_pos3 = WIDTH'(3 * LEVEL_A);
  localparam logic [PHW-1:0]          c_phase_last = PHW'(OSR - 1);
  localparam logic [CNT_W-1:0]        c_depth      = CNT_W'(FIFO_DEPTH);

  logic [1:0]              mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PHW-1:0]          phase_q, phase_d;
  logic signed [WIDTH-1:0] sample_q, sample_d;
  logic                    strobe_q, strobe_d;
  logic [7:0]              uf_cnt_q, uf_cnt_d;

  logic                    w_slot;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_underrun;
  logic signed [WIDTH-1:0] w_mapped;

  // Ready depends only on the registered occupancy, never on this cycle's pop
  assign sym_ready     = (count_q < c_depth);
  assign sample_out    = sample_q;
  assign sym_strobe    = strobe_q;
  assign underflow_cnt = uf_cnt_q;

  // A flush suppresses both FIFO ports; a slot during flush counts as underrun
  assign w_slot     = en && (phase_q == '0);
  assign w_empty    = (count_q == '0);
  assign w_push     = sym_valid && sym_ready && !flush;
  assign w_pop      = w_slot && !w_empty && !flush;
  assign w_underrun = w_slot && (w_empty || flush);

  // Gray map of the FIFO head symbol
  always_comb begin
    w_mapped = c_neg3;
    case (mem_q[rd_ptr_q])
      2'b00:   w_mapped = c_neg3;
      2'b01:   w_mapped = c_neg1;
      2'b11:   w_mapped = c_pos1;
      2'b10:   w_mapped = c_pos3;
      default: w_mapped = c_neg3;
    endcase
  end

  // Next-state: FIFO pointers/occupancy, phase counter, output sample and counter
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (w_push && !w_pop)      count_d = count_q + CNT_W'(1);
      else if (w_pop && !w_push) count_d = count_q - CNT_W'(1);
    end

    if (!en)                        phase_d = '0;
    else if (phase_q == c_phase_last) phase_d = '0;
    else                            phase_d = phase_q + PHW'(1);

    sample_d = w_pop ? w_mapped : '0;
    strobe_d = w_slot;

    uf_cnt_d = uf_cnt_q;
    if (w_underrun && (uf_cnt_q != 8'hFF)) uf_cnt_d = uf_cnt_q + 8'd1;
  end

  // Symbol storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= sym_data;
  end

  // State registers with asynchronous reset to an empty, idle stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      phase_q  <= '0;
      sample_q <= '0;
      strobe_q <= 1'b0;
      uf_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
      uf_cnt_q <= uf_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rrc_pam4_upsampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rrc_pam4_upsampler
// Brief    : Self-checking bench for rrc_pam4_upsampler. Accepted symbols are
//            queued with their expected amplitude; each slot pops the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rrc_pam4_upsampler;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              flush = 1'b0;
  logic [1:0]        sym_data = 2'b00;
  logic              sym_valid = 1'b0;
  logic              sym_ready;
  logic signed [8:0] sample_out;
  logic              sym_strobe;
  logic [7:0]        underflow_cnt;

  rrc_pam4_upsampler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .flush        (flush),
    .sym_data     (sym_data),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .sample_out   (sample_out),
    .sym_strobe   (sym_strobe),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int amp(input logic [1:0] s);
    case (s)
      2'b00:   return -192;
      2'b01:   return -64;
      2'b11:   return 64;
      default: return 192;
    endcase
  endfunction

  // Reference state
  int sb_q[$];
  int m_phase = 0;
  int m_uf = 0;
  int m_acc = 0;
  int e_sample = 0;
  int e_strobe = 0;

  // Reference model evaluated on the pre-edge inputs, compared shortly after
  always @(posedge clk) begin
    int  pre_size;
    bit  slot;
    bit  do_push;
    if (!rst_n) begin
      sb_q.delete();
      m_phase  = 0;
      m_uf     = 0;
      e_sample = 0;
      e_strobe = 0;
    end else begin
      slot     = en && (m_phase == 0);
      pre_size = sb_q.size();
      do_push  = sym_valid && (pre_size < 4) && !flush;
      e_strobe = slot;
      e_sample = 0;
      if (flush) begin
        sb_q.delete();
        if (slot && m_uf < 255) m_uf++;
      end else if (slot) begin
        if (pre_size > 0) e_sample = sb_q.pop_front();
        else if (m_uf < 255) m_uf++;
      end
      if (do_push) begin
        sb_q.push_back(amp(sym_data));
        m_acc++;
      end
      m_phase = !en ? 0 : ((m_phase == 3) ? 0 : m_phase + 1);
    end
    #1;
    chk("sample", int'(sample_out), e_sample);
    chk("strobe", int'(sym_strobe), e_strobe);
    chk("uf_cnt", int'(underflow_cnt), m_uf);
    chk("ready", int'(sym_ready), (sb_q.size() < 4) ? 1 : 0);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int acc0;
    logic [1:0] sweep [4];
    sweep[0] = 2'b00; sweep[1] = 2'b01; sweep[2] = 2'b11; sweep[3] = 2'b10;

    // Reset then idle
    step(3);
    chk("rst_ready", int'(sym_ready), 1);
    chk("rst_sample", int'(sample_out), 0);
    rst_n = 1'b1;
    step(10);

    // Mapping sweep: preload all four symbols, then stream
    for (int i = 0; i < 4; i++) begin
      sym_valid = 1'b1;
      sym_data  = sweep[i];
      step(1);
    end
    sym_valid = 1'b0;
    en = 1'b1;
    step(1);
    chk("sweep_first", int'(sample_out), -192);
    step(16);
    chk("sweep_uf", int'(underflow_cnt), 1);

    // Backpressure
    en = 1'b0;
    step(1);
    acc0 = m_acc;
    sym_valid = 1'b1;
    sym_data  = 2'b11;
    step(6);
    sym_valid = 1'b0;
    chk("bp_accepted", m_acc - acc0, 4);
    chk("bp_ready_low", int'(sym_ready), 0);
    en = 1'b1;
    step(1);
    chk("bp_ready_back", int'(sym_ready), 1);
    chk("bp_first", int'(sample_out), 64);
    step(15);
    en = 1'b0;
    step(2);

    // Underrun and saturation from a clean reset
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    en = 1'b1;
    step(40);
    chk("uf_10", int'(underflow_cnt), 10);
    step(1100);
    chk("uf_sat", int'(underflow_cnt), 255);
    en = 1'b0;

    // Flush and enable drop
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sym_valid = 1'b1;
      sym_data  = sweep[i];
      step(1);
    end
    sym_valid = 1'b0;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_ready", int'(sym_ready), 1);
    en = 1'b1;
    step(12);
    chk("flush_uf3", int'(underflow_cnt), 3);
    step(2);
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(1);
    chk("restart_strobe", int'(sym_strobe), 1);
    step(1);
    chk("restart_ph1", int'(sym_strobe), 0);
    en = 1'b0;
    step(2);

    // Reset mid-operation with +192 on the output and two symbols queued
    sym_valid = 1'b1;
    sym_data = 2'b10; step(1);
    sym_data = 2'b11; step(1);
    sym_data = 2'b11; step(1);
    sym_valid = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #3;
    chk("pre_rst_sample", int'(sample_out), 192);
    rst_n = 1'b0;
    #1;
    chk("async_sample", int'(sample_out), 0);
    chk("async_strobe", int'(sym_strobe), 0);
    chk("async_uf", int'(underflow_cnt), 0);
    chk("async_ready", int'(sym_ready), 1);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_strobe", int'(sym_strobe), 1);
    chk("post_rst_sample", int'(sample_out), 0);
    chk("post_rst_uf", int'(underflow_cnt), 1);
    step(8);
    en = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
